// File: rtl/proc_pkg.sv
// Shared definitions for the processor control unit.
//   - opcode_e : three-bit instruction opcodes
//   - state_e  : control FSM states (T0 fetch/idle, T1..T3 execute)
//   - field position constants for the IR word layout
// Optional feature macro used by the design: PROC_CTRL_MVNZ_EN.
package proc_pkg;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_MVNZ = 3'b100
    } opcode_e;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_e;

    // IR layout: opcode IR[8:6], X IR[5:3], Y IR[2:0]
    localparam int OP_MSB = 8;
    localparam int OP_LSB = 6;
    localparam int X_MSB  = 5;
    localparam int X_LSB  = 3;
    localparam int Y_MSB  = 2;
    localparam int Y_LSB  = 0;

endpackage

// File: rtl/proc_control_dec3to8.sv
// dec3to8: 3-to-8 one-hot decoder used for the X and Y register fields.
// Ports:
//   i_sel    [2:0] register index
//   o_onehot [7:0] one-hot select, bit i_sel set
module dec3to8 (
    input  logic [2:0] i_sel,
    output logic [7:0] o_onehot
);

    always_comb begin
        o_onehot = 8'h00;
        o_onehot[i_sel] = 1'b1;
    end

endmodule

// File: rtl/proc_control.sv
// proc_control: control FSM of a simple bus-based processor.
// Decodes the IR word and sequences mv / mvi (one execute cycle) and
// add / sub (three execute cycles). Outputs are purely combinational in
// state and IR; only the state is registered.
// Optional feature: define PROC_CTRL_MVNZ_EN to enable mvnz (opcode 100),
// which copies Ry to Rx only when G_nz is high.
// Ports:
//   Clock, Resetn     clock, asynchronous active-low reset
//   Run               start request, sampled only in T0
//   IR [WIDTH-1:0]    instruction word (opcode, X, Y)
//   G_nz              G register nonzero flag (mvnz only)
//   Rout, Rin [7:0]   one-hot register bus drive / load enables
//   Gout, DINout      G / DIN bus drive
//   IRin, Ain, Gin    IR / A / G load enables
//   AddSub            0 = add, 1 = subtract
//   Done              last cycle of an instruction
// The FSM state is visible internally as r_state for debug.
module proc_control
    import proc_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Run,
    input  logic [WIDTH-1:0] IR,
    input  logic             G_nz,
    output logic [7:0]       Rout,
    output logic [7:0]       Rin,
    output logic             Gout,
    output logic             DINout,
    output logic             IRin,
    output logic             Ain,
    output logic             Gin,
    output logic             AddSub,
    output logic             Done
);

    state_e  r_state;
    state_e  w_next;
    opcode_e w_op;
    logic [7:0] w_x_hot;
    logic [7:0] w_y_hot;
    logic       w_rout_x;
    logic       w_rout_y;
    logic       w_rin_x;
    logic       w_unused_in;

    assign w_op = opcode_e'(IR[OP_MSB:OP_LSB]);

    // Upper IR bits (WIDTH > 9) and, in the default build, G_nz carry no meaning.
    assign w_unused_in = ^{IR, G_nz};

    dec3to8 u_dec_x (
        .i_sel    (IR[X_MSB:X_LSB]),
        .o_onehot (w_x_hot)
    );

    dec3to8 u_dec_y (
        .i_sel    (IR[Y_MSB:Y_LSB]),
        .o_onehot (w_y_hot)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= T0;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_rout_x = 1'b0;
        w_rout_y = 1'b0;
        w_rin_x  = 1'b0;
        Gout     = 1'b0;
        DINout   = 1'b0;
        IRin     = 1'b0;
        Ain      = 1'b0;
        Gin      = 1'b0;
        AddSub   = 1'b0;
        Done     = 1'b0;
        case (r_state)
            T0: begin
                if (Run) begin
                    IRin   = 1'b1;
                    w_next = T1;
                end
            end
            T1: begin
                w_next = T0;
                case (w_op)
                    OP_MV: begin
                        w_rout_y = 1'b1;
                        w_rin_x  = 1'b1;
                        Done     = 1'b1;
                    end
                    OP_MVI: begin
                        DINout  = 1'b1;
                        w_rin_x = 1'b1;
                        Done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        w_rout_x = 1'b1;
                        Ain      = 1'b1;
                        w_next   = T2;
                    end
`ifdef PROC_CTRL_MVNZ_EN
                    OP_MVNZ: begin
                        w_rout_y = 1'b1;
                        w_rin_x  = G_nz;
                        Done     = 1'b1;
                    end
`endif
                    default: begin
                        // Undefined opcode: retire without touching any register.
                        Done = 1'b1;
                    end
                endcase
            end
            T2: begin
                w_rout_y = 1'b1;
                Gin      = 1'b1;
                AddSub   = (w_op == OP_SUB);
                w_next   = T3;
            end
            T3: begin
                Gout    = 1'b1;
                w_rin_x = 1'b1;
                Done    = 1'b1;
                w_next  = T0;
            end
            default: begin
                w_next = T0;
            end
        endcase
    end

    // Only one register select is ever active per cycle, so Rout stays one-hot.
    assign Rout = (w_rout_x ? w_x_hot : 8'h00) | (w_rout_y ? w_y_hot : 8'h00);
    assign Rin  = w_rin_x ? w_x_hot : 8'h00;

endmodule

// File: tb/tb_proc_control.sv
module tb_proc_control;
  import proc_pkg::*;

  localparam int W = 23;  // {Rout, Rin, Gout, DINout, IRin, Ain, Gin, AddSub, Done}

  logic       Clock;
  logic       Resetn;
  logic       Run;
  logic [8:0] IR;
  logic       G_nz;
  logic [7:0] Rout;
  logic [7:0] Rin;
  logic       Gout;
  logic       DINout;
  logic       IRin;
  logic       Ain;
  logic       Gin;
  logic       AddSub;
  logic       Done;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks;
  int           errors;

  proc_control #(.WIDTH(9)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Run    (Run),
    .IR     (IR),
    .G_nz   (G_nz),
    .Rout   (Rout),
    .Rin    (Rin),
    .Gout   (Gout),
    .DINout (DINout),
    .IRin   (IRin),
    .Ain    (Ain),
    .Gin    (Gin),
    .AddSub (AddSub),
    .Done   (Done)
  );

  // ---------------- clock / reset ----------------
  // Clock starts high so the first falling edge precedes the first rising edge.
  initial begin
    Clock = 1'b1;
    forever #5 Clock = ~Clock;
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk(input logic [7:0] rout, input logic [7:0] rin,
                                      input logic gout, input logic din, input logic irin,
                                      input logic ain, input logic gin, input logic addsub,
                                      input logic done);
    return {rout, rin, gout, din, irin, ain, gin, addsub, done};
  endfunction

  function automatic logic [W-1:0] actual();
    return {Rout, Rin, Gout, DINout, IRin, Ain, Gin, AddSub, Done};
  endfunction

  localparam logic [W-1:0] ZERO = '0;

  // ---------------- driver ----------------
  // Drive one cycle of inputs and queue the outputs expected during that cycle.
  task automatic step(input logic run, input logic [8:0] ir, input logic gnz,
                      input logic [W-1:0] exp_v, input string nm);
    Run  = run;
    IR   = ir;
    G_nz = gnz;
    exp_q.push_back(exp_v);
    name_q.push_back(nm);
    @(posedge Clock);
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge Clock);
      if (exp_q.size() > 0) begin
        logic [W-1:0] e;
        string        n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (actual() !== e) begin
          errors++;
          $display("FAIL %s: got %h expected %h", n, actual(), e);
        end
      end
    end
  end

  // ---------------- structural invariants ----------------
  initial begin
    forever begin
      @(negedge Clock);
      checks++;
      if (!$onehot0({Rout, Gout, DINout})) begin
        errors++;
        $display("FAIL bus_drivers: got Rout=%h Gout=%b DINout=%b required at most one", Rout, Gout, DINout);
      end
      checks++;
      if (!$onehot0(Rin)) begin
        errors++;
        $display("FAIL rin_onehot: got %h required at most one bit", Rin);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] mvnz_g0;
    logic [W-1:0] mvnz_g1;
    checks = 0;
    errors = 0;
    Resetn = 1'b0;
    Run    = 1'b0;
    IR     = '0;
    G_nz   = 1'b0;

`ifdef PROC_CTRL_MVNZ_EN
    mvnz_g0 = mk(8'h20, 8'h00, 0, 0, 0, 0, 0, 0, 1);
    mvnz_g1 = mk(8'h20, 8'h10, 0, 0, 0, 0, 0, 0, 1);
`else
    mvnz_g0 = mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1);
    mvnz_g1 = mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1);
`endif

    // Reset state
    step(0, 9'o000, 0, ZERO, "reset_0");
    step(0, 9'o000, 0, ZERO, "reset_1");
    Resetn = 1'b1;
    step(0, 9'o000, 0, ZERO, "idle_after_reset");

    // mvi R0
    step(1, 9'o100, 0, mk(8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0), "mvi_irin");
    step(0, 9'o100, 0, mk(8'h00, 8'h01, 0, 1, 0, 0, 0, 0, 1), "mvi_t1");
    step(0, 9'o100, 0, ZERO, "mvi_back_t0");

    // mv R1,R0
    step(1, 9'o010, 0, mk(8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0), "mv_irin");
    step(0, 9'o010, 0, mk(8'h01, 8'h02, 0, 0, 0, 0, 0, 0, 1), "mv_t1");
    step(0, 9'o010, 0, ZERO, "mv_back_t0");

    // add R0,R1 then sub R2,R3 back to back, Run held high throughout
    step(1, 9'o201, 0, mk(8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0), "add_irin");
    step(1, 9'o201, 0, mk(8'h01, 8'h00, 0, 0, 0, 1, 0, 0, 0), "add_t1");
    step(1, 9'o201, 0, mk(8'h02, 8'h00, 0, 0, 0, 0, 1, 0, 0), "add_t2");
    step(1, 9'o201, 0, mk(8'h00, 8'h01, 1, 0, 0, 0, 0, 0, 1), "add_t3");
    step(1, 9'o323, 0, mk(8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0), "sub_irin");
    step(1, 9'o323, 0, mk(8'h04, 8'h00, 0, 0, 0, 1, 0, 0, 0), "sub_t1");
    step(1, 9'o323, 0, mk(8'h08, 8'h00, 0, 0, 0, 0, 1, 1, 0), "sub_t2");
    step(0, 9'o323, 0, mk(8'h00, 8'h04, 1, 0, 0, 0, 0, 0, 1), "sub_t3");
    step(0, 9'o323, 0, ZERO, "sub_back_t0");

    // Undefined opcode 7
    step(1, 9'o777, 0, mk(8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0), "undef_irin");
    step(0, 9'o777, 0, mk(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1), "undef_t1");
    step(0, 9'o777, 0, ZERO, "undef_back_t0");

    // mvnz R4,R5 with G_nz low then high
    step(1, 9'o445, 0, mk(8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0), "mvnz0_irin");
    step(0, 9'o445, 0, mvnz_g0, "mvnz0_t1");
    step(1, 9'o445, 1, mk(8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0), "mvnz1_irin");
    step(0, 9'o445, 1, mvnz_g1, "mvnz1_t1");
    step(0, 9'o445, 0, ZERO, "mvnz_back_t0");

    // Reset asserted mid-T2 of an add
    step(1, 9'o201, 0, mk(8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0), "rst_add_irin");
    step(0, 9'o201, 0, mk(8'h01, 8'h00, 0, 0, 0, 1, 0, 0, 0), "rst_add_t1");
    Run = 1'b0;
    exp_q.push_back(mk(8'h02, 8'h00, 0, 0, 0, 0, 1, 0, 0));
    name_q.push_back("rst_add_t2");
    @(negedge Clock);
    #1;
    Resetn = 1'b0;
    #1;
    checks++;
    if (dut.r_state !== T0) begin
      errors++;
      $display("FAIL async_reset_state: got %0d expected %0d", dut.r_state, T0);
    end
    checks++;
    if (actual() !== ZERO) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h expected %h", actual(), ZERO);
    end
    @(posedge Clock);
    #1;
    step(0, 9'o201, 0, ZERO, "rst_held_0");
    step(0, 9'o201, 0, ZERO, "rst_held_1");
    Resetn = 1'b1;
    step(0, 9'o201, 0, ZERO, "rst_release_0");
    step(0, 9'o201, 0, ZERO, "rst_release_1");
    step(0, 9'o201, 0, ZERO, "rst_release_2");

    // Execution resumes normally
    step(1, 9'o010, 0, mk(8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0), "resume_irin");
    step(0, 9'o010, 0, mk(8'h01, 8'h02, 0, 0, 0, 0, 0, 0, 1), "resume_t1");
    step(0, 9'o000, 0, ZERO, "resume_back_t0");

    // Let the monitor drain and confirm nothing was left unchecked
    @(posedge Clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_control.md
PROC_CONTROL -- requirements
Module: proc_control

Interface
REQ-001 Parameter WIDTH, default 9, instruction word width; the module SHALL support WIDTH >= 9.
REQ-002 Ports SHALL be, clock and reset first:
  Clock  input  1  single clock, all state changes on the rising edge.
  Resetn  input  1  asynchronous, active-low reset.
  Run  input  1  start request for one instruction.
  IR  input  WIDTH  instruction from the IR register: opcode IR[8:6], X IR[5:3], Y IR[2:0].
  G_nz  input  1  high when the G register is nonzero; used only with PROC_CTRL_MVNZ_EN.
  Rout  output  8  one-hot enable that drives register Rn onto the bus.
  Rin  output  8  one-hot load enable for register Rn.
  Gout, DINout  output  1 each  drive G or DIN onto the bus.
  IRin, Ain, Gin  output  1 each  load enables for IR, A and G.
  AddSub  output  1  0 = add, 1 = subtract.
  Done  output  1  pulse marking the final cycle of an instruction.

Function
REQ-003 The FSM SHALL have the states T0 (fetch/idle), T1, T2 and T3.
REQ-004 All outputs SHALL be combinational functions of the current state and IR; the next state SHALL be registered.
REQ-005 In T0, the block SHALL assert IRin only while Run=1 and SHALL move to T1 on that edge; with Run=0 it SHALL stay in T0 with all outputs 0.
REQ-006 mv Rx,Ry (opcode 000) SHALL complete in T1: Rout[Y]=1, Rin[X]=1, Done=1, next state T0.
REQ-007 mvi Rx,#D (opcode 001) SHALL complete in T1: DINout=1, Rin[X]=1, Done=1, next state T0.
REQ-008 add (010) and sub (011) SHALL run as follows:
  T1: Rout[X]=1, Ain=1.
  T2: Rout[Y]=1, Gin=1, AddSub = 1 for sub and 0 for add.
  T3: Gout=1, Rin[X]=1, Done=1, next state T0.
REQ-009 Undefined opcodes SHALL assert only Done in T1 and return to T0, with no register written.
REQ-010 At most one bus driver (any Rout bit, Gout or DINout) SHALL be asserted in any cycle.
REQ-011 Every Rin and Rout vector SHALL have at most one bit set.
REQ-012 AddSub SHALL be 0 in every cycle except T2 of a sub.
REQ-013 IR SHALL be sampled combinationally each cycle; the datapath holds IR stable from T1 to T3.
REQ-014 Run SHALL be ignored outside T0.
REQ-015 Back-to-back instructions SHALL be supported: after Done returns to T0, Run=1 loads the next IR with no idle cycle.
REQ-016 Latency from the IRin cycle SHALL be 1 cycle for mv and mvi, and 3 cycles for add and sub.

Reset
REQ-017 Resetn=0 SHALL force state T0 immediately, independent of Clock, so that every output is 0 while Run=0.
REQ-018 A reset during T1 to T3 SHALL abort the instruction with no further Rin, Gin or Done assertions; execution resumes at T0 after release.

Configuration
REQ-019 With macro PROC_CTRL_MVNZ_EN defined, opcode 100 SHALL be mvnz Rx,Ry. In T1 it SHALL assert Rout[Y]=1 and Done=1, and SHALL assert Rin[X]=1 only if G_nz=1.
REQ-020 Without PROC_CTRL_MVNZ_EN, opcode 100 SHALL be treated as undefined (REQ-009) and G_nz SHALL be unused.

Structure
REQ-021 The shared package proc_pkg SHALL hold:
  - the opcode enum (OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_MVNZ);
  - the state enum (T0 to T3);
  - the field position constants.
REQ-022 The 3-to-8 one-hot decoding of X and Y SHALL use one sub-module, dec3to8, instantiated twice.

Verification
REQ-023 Reset: hold Resetn=0 mid-T2 of an add -> state goes to T0 at once, all outputs 0, and no Rin/Gin pulse follows release.
REQ-024 mvi R0: IR=9'o100, Run=1 -> IRin in cycle 0; in cycle 1 DINout=1, Rin=8'h01, Done=1; state returns to T0.
REQ-025 mv R1,R0: IR=9'o010 -> in T1 Rout=8'h01, Rin=8'h02, Done=1.
REQ-026 add R0,R1: IR=9'o201 -> the following sequence, with Done only in T3:
  T1: Rout=8'h01, Ain=1.
  T2: Rout=8'h02, Gin=1, AddSub=0.
  T3: Gout=1, Rin=8'h01, Done=1.
REQ-027 sub R2,R3 issued back-to-back after add: IR=9'o323 with Run held high -> IRin is asserted in the cycle after Done, and T2 has AddSub=1 with Rout=8'h08.
REQ-028 mvnz R4,R5: IR=9'o445 -> with the macro and G_nz=0, Rin=0 and Done=1; with G_nz=1, Rin=8'h10. Without the macro, only Done is asserted.
REQ-029 Every scenario SHALL include continuous assertions of REQ-010 and REQ-011.
